pb_irq_controller: RTL and testbench
====================================

PB_IRQ_CONTROLLER -- requirements
Module: pb_irq_controller

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources; legal range 1..32.
REQ-002 Parameter VEC_W, default 3: vector width; must satisfy 2^VEC_W >= N_SRC.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous reset, active-low.
REQ-006 int_src  input  N_SRC  interrupt sources, already synchronous to clk_i.
REQ-007 int_mask  input  N_SRC  per-source enable; 1 = enabled.
REQ-008 int_edge  input  N_SRC  per-source mode; 1 = rising-edge, 0 = level.
REQ-009 int_clear  input  N_SRC  per-source one-cycle clear pulse from firmware.
REQ-010 int_ack_i  input  1  CPU interrupt acknowledge pulse.
REQ-011 int_eoi_i  input  1  end-of-interrupt pulse from firmware.
REQ-012 interrupts  output  N_SRC  raw pending bits; unmasked by int_mask.
REQ-013 int_vector  output  VEC_W  index of the source being serviced.
REQ-014 int_valid  output  1  int_vector is valid; high only in SERVICE.
REQ-015 int_o  output  1  registered interrupt request to the CPU.

Function
REQ-016 Edge detection SHALL use a one-stage register src_q of int_src; an edge source is detected when int_src=1 and src_q=0.
REQ-017 Pending setting SHALL follow the source mode: an edge source sets its pending bit on a detected edge; a level source sets it in every cycle its int_src is 1.
REQ-018 An int_clear bit SHALL clear its pending bit on the next edge; if set and clear coincide, set SHALL win.
REQ-019 Changing int_mask SHALL NOT alter pending bits.
REQ-020 The vector SHALL use fixed priority: the lowest index of (pending & int_mask) wins.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 In IDLE, if any (pending & int_mask) bit is 1, the FSM SHALL move to REQ and int_o SHALL be 1 from the next cycle.
REQ-023 In REQ with int_ack_i=1 and (pending & int_mask) non-zero, the FSM SHALL move to SERVICE; int_vector SHALL latch the winner in that ack cycle; int_valid SHALL go 1 and int_o SHALL go 0.
REQ-024 In REQ, if (pending & int_mask) becomes 0, with or without int_ack_i, the FSM SHALL return to IDLE; int_o SHALL go 0 and int_valid SHALL stay 0.
REQ-025 In SERVICE, int_eoi_i SHALL return the FSM to IDLE and clear int_valid; int_vector SHALL hold its last value.
REQ-026 int_ack_i outside REQ and int_eoi_i outside SERVICE SHALL be ignored.
REQ-027 Pending bits SHALL continue to accumulate in SERVICE; if any are still unmasked after EOI, int_o SHALL reassert 2 cycles after the int_eoi_i cycle (via IDLE, then REQ).
REQ-028 Latency: for an edge on int_src sampled at edge n, the pending bit SHALL be 1 after edge n+1 and int_o SHALL be 1 after edge n+2.
REQ-029 Acknowledge SHALL NOT clear pending bits; firmware clears them via int_clear.

Reset
REQ-030 While rst_i=0 at a clock edge, the following SHALL be forced: pending=0, state=IDLE, int_o=0, int_valid=0, int_vector=0.
REQ-031 During reset, src_q SHALL load int_src so that a source already high at reset release produces no edge.
REQ-032 Reset SHALL take priority over all other inputs, including mid-SERVICE and mid-REQ.

Configuration
REQ-033 With PB_IRQ_EDGE_EN defined, int_edge SHALL be honoured per REQ-016 and REQ-017.
REQ-034 With PB_IRQ_EDGE_EN undefined, src_q SHALL be omitted, int_edge SHALL be ignored and every source SHALL behave as level.

Verification
REQ-035 N_SRC=8, mask=0xFF, edge=0x01, pulse src[0] for 1 cycle -> interrupts[0]=1 after 1 cycle; int_o=1 after 2 cycles; pending stays 1 after src drops.
REQ-036 Set pending for src[5] and src[2], then pulse ack -> int_vector=2, int_valid=1, int_o=0; EOI with both still pending -> int_o=1 two cycles later.
REQ-037 Level src[3]=1 with clear[3] pulsed -> interrupts[3] stays 1; drop src[3] and pulse clear[3] -> interrupts[3]=0.
REQ-038 REQ state, clear the only pending bit before ack -> FSM returns to IDLE, int_o=0; a subsequent ack -> int_valid stays 0.
REQ-039 Assert rst_i=0 in SERVICE while src[1]=1 -> all outputs 0; release reset with src[1] still high and edge[1]=1 -> no interrupt raised.
REQ-040 Build without PB_IRQ_EDGE_EN, edge=0xFF, hold src[4] high -> interrupts[4] tracks the level; clear[4] has no effect while src[4]=1.

Source files
------------

// File: rtl/pb_irq_controller.sv
// pb_irq_controller: prioritised interrupt controller.
//   Per-source pending latches (level or rising-edge), fixed lowest-index
//   priority, and an IDLE -> REQ -> SERVICE handshake (int_o / ack / eoi).
// Configuration macro: PB_IRQ_EDGE_EN
//   defined   : int_edge selects rising-edge detection per source.
//   undefined : src_q is omitted, int_edge is ignored, all sources are level.
module pb_irq_controller #(
  parameter int N_SRC = 8,  // number of sources, 1..32
  parameter int VEC_W = 3   // 2**VEC_W >= N_SRC
) (
  input  logic             clk_i,
  input  logic             rst_i,       // synchronous, active-low
  input  logic [N_SRC-1:0] int_src,
  input  logic [N_SRC-1:0] int_mask,
  input  logic [N_SRC-1:0] int_edge,
  input  logic [N_SRC-1:0] int_clear,
  input  logic             int_ack_i,
  input  logic             int_eoi_i,
  output logic [N_SRC-1:0] interrupts,
  output logic [VEC_W-1:0] int_vector,
  output logic             int_valid,
  output logic             int_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_reg;
  logic             int_o_reg;
  logic             int_valid_reg;
  logic [VEC_W-1:0] int_vector_reg;

  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] active;
  logic             any_active;
  logic [VEC_W-1:0] winner;

`ifdef PB_IRQ_EDGE_EN
  logic [N_SRC-1:0] src_q_reg;

  // Previous-cycle copy of the sources; loading it during reset too means a
  // source already high at reset release does not look like a fresh edge.
  always_ff @(posedge clk_i) begin
    src_q_reg <= int_src;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_set_edge
      assign set_vec[gi] = int_edge[gi] ? (int_src[gi] & ~src_q_reg[gi])
                                        : int_src[gi];
    end
  endgenerate
`else
  // Level-only build: every asserted source requests in every cycle.
  assign set_vec = int_src;

  logic unused_edge;
  assign unused_edge = ^int_edge;
`endif

  // Per-source pending update: a set in the same cycle beats a clear.
  genvar gp;
  generate
    for (gp = 0; gp < N_SRC; gp++) begin : g_pending
      assign pending_next[gp] = set_vec[gp] | (pending_reg[gp] & ~int_clear[gp]);
    end
  endgenerate

  // Pending register; the mask never touches it, only set/clear do.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign active     = pending_reg & int_mask;
  assign any_active = |active;

  // Fixed priority: scan high to low so the lowest active index ends up last.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner = VEC_W'(i);
      end
    end
  end

  // Request/acknowledge/end-of-interrupt handshake with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      int_o_reg      <= 1'b0;
      int_valid_reg  <= 1'b0;
      int_vector_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_active) begin
            state_reg <= REQ;
            int_o_reg <= 1'b1;
          end
        end
        REQ: begin
          if (!any_active) begin
            // Request withdrawn before (or together with) the ack.
            state_reg <= IDLE;
            int_o_reg <= 1'b0;
          end else if (int_ack_i) begin
            state_reg      <= SERVICE;
            int_o_reg      <= 1'b0;
            int_valid_reg  <= 1'b1;
            int_vector_reg <= winner;
          end
        end
        SERVICE: begin
          // Vector is kept after EOI so firmware can still read it.
          if (int_eoi_i) begin
            state_reg     <= IDLE;
            int_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          int_o_reg     <= 1'b0;
          int_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign interrupts = pending_reg;
  assign int_vector = int_vector_reg;
  assign int_valid  = int_valid_reg;
  assign int_o      = int_o_reg;

endmodule

// File: tb/tb_pb_irq_controller.sv
// Directed testbench for pb_irq_controller (N_SRC=8, VEC_W=3).
// Expectations that depend on PB_IRQ_EDGE_EN are selected with the same macro.
module tb_pb_irq_controller;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] int_src;
  logic [7:0] int_mask;
  logic [7:0] int_edge;
  logic [7:0] int_clear;
  logic       int_ack_i;
  logic       int_eoi_i;
  logic [7:0] interrupts;
  logic [2:0] int_vector;
  logic       int_valid;
  logic       int_o;

  int tests_run;
  int tests_failed;

  pb_irq_controller #(.N_SRC(8), .VEC_W(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .int_src    (int_src),
    .int_mask   (int_mask),
    .int_edge   (int_edge),
    .int_clear  (int_clear),
    .int_ack_i  (int_ack_i),
    .int_eoi_i  (int_eoi_i),
    .interrupts (interrupts),
    .int_vector (int_vector),
    .int_valid  (int_valid),
    .int_o      (int_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; int_src = 8'hFF; int_mask = 8'hFF; int_edge = 8'h00;
    tick; tick; tick;
    tests_run++;
    if (interrupts !== 8'h00) begin tests_failed++; $display("FAIL reset_pending got=%h exp=%h", interrupts, 8'h00); end
    tests_run++;
    if (int_o !== 1'b0 || int_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_o_valid got=%b%b exp=00", int_o, int_valid); end
    tests_run++;
    if (int_vector !== 3'd0) begin tests_failed++; $display("FAIL reset_vector got=%0d exp=0", int_vector); end
    int_src = 8'h00;
    tick;
    rst_i = 1'b1;
    tick;
    tests_run++;
    if (interrupts !== 8'h00 || int_o !== 1'b0) begin tests_failed++; $display("FAIL reset_release got=%h/%b exp=00/0", interrupts, int_o); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_pulse;
    int_mask = 8'hFF; int_edge = 8'h01;
    int_src = 8'h01;
    tick;
    int_src = 8'h00;
    tests_run++;
    if (interrupts !== 8'h01) begin tests_failed++; $display("FAIL pulse_pending got=%h exp=%h", interrupts, 8'h01); end
    tests_run++;
    if (int_o !== 1'b0) begin tests_failed++; $display("FAIL pulse_o_early got=%b exp=0", int_o); end
    tick;
    tests_run++;
    if (int_o !== 1'b1) begin tests_failed++; $display("FAIL pulse_o got=%b exp=1", int_o); end
    tests_run++;
    if (interrupts !== 8'h01) begin tests_failed++; $display("FAIL pulse_hold got=%h exp=%h", interrupts, 8'h01); end
    tick;
    // Clear the only pending bit while in REQ, before any ack.
    int_clear = 8'h01;
    tick;
    int_clear = 8'h00;
    tests_run++;
    if (interrupts !== 8'h00) begin tests_failed++; $display("FAIL pulse_clear got=%h exp=%h", interrupts, 8'h00); end
    tick;
    tests_run++;
    if (int_o !== 1'b0) begin tests_failed++; $display("FAIL req_withdraw_o got=%b exp=0", int_o); end
    int_ack_i = 1'b1;
    tick;
    int_ack_i = 1'b0;
    tests_run++;
    if (int_valid !== 1'b0 || int_o !== 1'b0) begin tests_failed++; $display("FAIL late_ack got=%b%b exp=00", int_valid, int_o); end
    $display("[TB] test_pulse done");
  endtask

  task automatic test_priority;
    int_mask = 8'hFF; int_edge = 8'h00;
    int_src = 8'h24;
    tick;
    int_src = 8'h00;
    tick;
    tests_run++;
    if (interrupts !== 8'h24 || int_o !== 1'b1) begin tests_failed++; $display("FAIL prio_req got=%h/%b exp=24/1", interrupts, int_o); end
    int_ack_i = 1'b1;
    tick;
    int_ack_i = 1'b0;
    tests_run++;
    if (int_vector !== 3'd2) begin tests_failed++; $display("FAIL prio_vector got=%0d exp=2", int_vector); end
    tests_run++;
    if (int_valid !== 1'b1 || int_o !== 1'b0) begin tests_failed++; $display("FAIL prio_service got=%b%b exp=10", int_valid, int_o); end
    tests_run++;
    if (interrupts !== 8'h24) begin tests_failed++; $display("FAIL ack_keeps_pending got=%h exp=24", interrupts); end
    int_ack_i = 1'b1;
    tick;
    int_ack_i = 1'b0;
    tests_run++;
    if (int_valid !== 1'b1 || int_vector !== 3'd2) begin tests_failed++; $display("FAIL ack_in_service got=%b/%0d exp=1/2", int_valid, int_vector); end
    int_eoi_i = 1'b1;
    tick;
    int_eoi_i = 1'b0;
    tests_run++;
    if (int_valid !== 1'b0 || int_o !== 1'b0 || int_vector !== 3'd2) begin tests_failed++; $display("FAIL eoi got=%b%b/%0d exp=00/2", int_valid, int_o, int_vector); end
    tick;
    tests_run++;
    if (int_o !== 1'b1) begin tests_failed++; $display("FAIL eoi_reassert got=%b exp=1", int_o); end
    int_clear = 8'h24;
    tick;
    int_clear = 8'h00;
    tick;
    tests_run++;
    if (interrupts !== 8'h00 || int_o !== 1'b0) begin tests_failed++; $display("FAIL prio_cleanup got=%h/%b exp=00/0", interrupts, int_o); end
    $display("[TB] test_priority done");
  endtask

  task automatic test_mask;
    int_mask = 8'hFF; int_edge = 8'h00;
    int_src = 8'h05;
    tick;
    int_src = 8'h00;
    int_mask = 8'hFE;
    tick;
    tests_run++;
    if (int_o !== 1'b1) begin tests_failed++; $display("FAIL mask_req got=%b exp=1", int_o); end
    int_eoi_i = 1'b1;
    tick;
    int_eoi_i = 1'b0;
    tests_run++;
    if (int_o !== 1'b1 || int_valid !== 1'b0) begin tests_failed++; $display("FAIL eoi_in_req got=%b%b exp=10", int_o, int_valid); end
    int_ack_i = 1'b1;
    tick;
    int_ack_i = 1'b0;
    tests_run++;
    if (int_vector !== 3'd2 || int_valid !== 1'b1) begin tests_failed++; $display("FAIL mask_vector got=%0d/%b exp=2/1", int_vector, int_valid); end
    int_eoi_i = 1'b1;
    tick;
    int_eoi_i = 1'b0;
    int_mask = 8'h00;
    tick;
    tests_run++;
    if (interrupts !== 8'h05) begin tests_failed++; $display("FAIL mask_keeps_pending got=%h exp=05", interrupts); end
    tests_run++;
    if (int_o !== 1'b0) begin tests_failed++; $display("FAIL mask_no_req got=%b exp=0", int_o); end
    int_clear = 8'h05;
    tick;
    int_clear = 8'h00;
    int_mask = 8'hFF;
    tick;
    tests_run++;
    if (interrupts !== 8'h00 || int_o !== 1'b0) begin tests_failed++; $display("FAIL mask_cleanup got=%h/%b exp=00/0", interrupts, int_o); end
    $display("[TB] test_mask done");
  endtask

  task automatic test_level_clear;
    int_mask = 8'hFF; int_edge = 8'h00;
    int_src = 8'h08;
    tick;
    tests_run++;
    if (interrupts !== 8'h08) begin tests_failed++; $display("FAIL level_set got=%h exp=08", interrupts); end
    int_clear = 8'h08;
    tick;
    tests_run++;
    if (interrupts !== 8'h08) begin tests_failed++; $display("FAIL set_beats_clear got=%h exp=08", interrupts); end
    int_clear = 8'h00; int_src = 8'h00;
    tick;
    tests_run++;
    if (interrupts !== 8'h08) begin tests_failed++; $display("FAIL level_hold got=%h exp=08", interrupts); end
    int_clear = 8'h08;
    tick;
    int_clear = 8'h00;
    tests_run++;
    if (interrupts !== 8'h00) begin tests_failed++; $display("FAIL level_cleared got=%h exp=00", interrupts); end
    tick; tick;
    tests_run++;
    if (int_o !== 1'b0) begin tests_failed++; $display("FAIL level_idle got=%b exp=0", int_o); end
    $display("[TB] test_level_clear done");
  endtask

  task automatic test_edge_config;
    logic [7:0] exp_after_clear;
`ifdef PB_IRQ_EDGE_EN
    exp_after_clear = 8'h00;
`else
    exp_after_clear = 8'h10;
`endif
    int_mask = 8'hFF; int_edge = 8'hFF;
    int_src = 8'h10;
    tick;
    tests_run++;
    if (interrupts !== 8'h10) begin tests_failed++; $display("FAIL cfg_set got=%h exp=10", interrupts); end
    int_clear = 8'h10;
    tick;
    int_clear = 8'h00;
    tests_run++;
    if (interrupts !== exp_after_clear) begin tests_failed++; $display("FAIL cfg_clear_held got=%h exp=%h", interrupts, exp_after_clear); end
    tick;
    tests_run++;
    if (interrupts !== exp_after_clear) begin tests_failed++; $display("FAIL cfg_track got=%h exp=%h", interrupts, exp_after_clear); end
    int_src = 8'h00; int_clear = 8'h10;
    tick;
    int_clear = 8'h00;
    tests_run++;
    if (interrupts !== 8'h00) begin tests_failed++; $display("FAIL cfg_drop_clear got=%h exp=00", interrupts); end
    tick; tick;
    tests_run++;
    if (int_o !== 1'b0 || int_valid !== 1'b0) begin tests_failed++; $display("FAIL cfg_idle got=%b%b exp=00", int_o, int_valid); end
    $display("[TB] test_edge_config done");
  endtask

  task automatic test_reset_mid_service;
    logic [7:0] exp_pend;
    logic       exp_o;
`ifdef PB_IRQ_EDGE_EN
    exp_pend = 8'h00; exp_o = 1'b0;
`else
    exp_pend = 8'h02; exp_o = 1'b1;
`endif
    int_mask = 8'hFF; int_edge = 8'h02;
    int_src = 8'h02;
    tick; tick;
    int_ack_i = 1'b1;
    tick;
    int_ack_i = 1'b0;
    tests_run++;
    if (int_valid !== 1'b1 || int_vector !== 3'd1) begin tests_failed++; $display("FAIL rs_service got=%b/%0d exp=1/1", int_valid, int_vector); end
    rst_i = 1'b0;
    tick;
    tests_run++;
    if (interrupts !== 8'h00 || int_o !== 1'b0 || int_valid !== 1'b0 || int_vector !== 3'd0) begin
      tests_failed++; $display("FAIL rs_forced got=%h/%b%b/%0d exp=00/00/0", interrupts, int_o, int_valid, int_vector);
    end
    rst_i = 1'b1;
    tick;
    tests_run++;
    if (interrupts !== exp_pend) begin tests_failed++; $display("FAIL rs_release_pend got=%h exp=%h", interrupts, exp_pend); end
    tick;
    tests_run++;
    if (int_o !== exp_o) begin tests_failed++; $display("FAIL rs_release_o got=%b exp=%b", int_o, exp_o); end
    int_src = 8'h00; int_clear = 8'h02;
    tick;
    int_clear = 8'h00;
    tick; tick;
    tests_run++;
    if (interrupts !== 8'h00 || int_o !== 1'b0) begin tests_failed++; $display("FAIL rs_cleanup got=%h/%b exp=00/0", interrupts, int_o); end
    $display("[TB] test_reset_mid_service done");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_i = 1'b0; int_src = 8'h00; int_mask = 8'h00; int_edge = 8'h00;
    int_clear = 8'h00; int_ack_i = 1'b0; int_eoi_i = 1'b0;
    #2;
    test_reset;
    test_pulse;
    test_priority;
    test_mask;
    test_level_clear;
    test_edge_config;
    test_reset_mid_service;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
